// File: rtl/rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// rf_access_ctrl
//
// Initiator/controller for a 256x16 synchronous register-file macro. A client
// requests single or burst (1..8 beat) reads and writes over a valid/ready
// handshake. The controller drives the macro pins one beat per cycle with
// address auto-increment and returns read data with a fixed 2-cycle latency
// measured from the cycle the read command is on the pins.
//
// Ports:
//   CLK        clock, all logic on posedge
//   NRST       asynchronous active-low reset
//   REQ_VALID  client request valid
//   REQ_READY  high while idle; a request is taken when REQ_VALID is also high
//   REQ_WR     1 = write burst, 0 = read burst
//   REQ_ADDR   start address {RA,CA}
//   REQ_LEN    beats minus one
//   WDATA      write beat data
//   WD_VALID   write beat valid
//   WD_READY   high while write beats are being accepted
//   RDATA      read beat data
//   RD_VALID   RDATA valid for one cycle, no backpressure
//   DONE       one-cycle pulse at burst completion
//   NCE        macro chip enable, active low, registered
//   NWRT       macro write enable, active low, registered
//   RA         macro row address, registered
//   CA         macro column address, registered
//   DIN        macro write data, registered
//   DO         macro read data
// -----------------------------------------------------------------------------
module rf_access_ctrl #(
  parameter int DW   = 16,
  parameter int RAW  = 6,
  parameter int CAW  = 2,
  parameter int LENW = 3
) (
  input  logic               CLK,
  input  logic               NRST,
  input  logic               REQ_VALID,
  output logic               REQ_READY,
  input  logic               REQ_WR,
  input  logic [RAW+CAW-1:0] REQ_ADDR,
  input  logic [LENW-1:0]    REQ_LEN,
  input  logic [DW-1:0]      WDATA,
  input  logic               WD_VALID,
  output logic               WD_READY,
  output logic [DW-1:0]      RDATA,
  output logic               RD_VALID,
  output logic               DONE,
  output logic               NCE,
  output logic               NWRT,
  output logic [RAW-1:0]     RA,
  output logic [CAW-1:0]     CA,
  output logic [DW-1:0]      DIN,
  input  logic [DW-1:0]      DO
);

  localparam int AW = RAW + CAW;

  localparam logic [AW-1:0]   ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WDONE = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   addr_r;
  logic [AW-1:0]   addr_s;
  logic [LENW-1:0] cnt_r;
  logic [LENW-1:0] cnt_s;

  logic            nce_r;
  logic            nce_s;
  logic            nwrt_r;
  logic            nwrt_s;
  logic [AW-1:0]   pin_addr_r;
  logic [AW-1:0]   pin_addr_s;
  logic [DW-1:0]   din_r;
  logic [DW-1:0]   din_s;

  // pipe_r[0]: a read command is on the pins this cycle
  // pipe_r[1]: DO carries the data of the previous cycle's read command
  logic [1:0]      pipe_r;
  logic            issue_rd_s;

  logic            done_r;
  logic            done_s;
  logic [DW-1:0]   rdata_r;
  logic [DW-1:0]   rdata_s;
  logic            rd_valid_r;

  // Next-state, address/count and pin command decode
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    cnt_s      = cnt_r;
    nce_s      = 1'b1;
    nwrt_s     = 1'b1;
    pin_addr_s = pin_addr_r;
    din_s      = din_r;
    issue_rd_s = 1'b0;
    done_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID) begin
          if (REQ_WR) begin
            // Write data is not yet available, so the first beat waits
            // for WD_VALID in WRITE.
            addr_s  = REQ_ADDR;
            cnt_s   = REQ_LEN;
            state_s = ST_WRITE;
          end else begin
            // The first read beat goes out on the accept edge so that it
            // is on the pins in the cycle right after acceptance.
            nce_s      = 1'b0;
            pin_addr_s = REQ_ADDR;
            issue_rd_s = 1'b1;
            addr_s     = REQ_ADDR + ADDR_ONE;
            cnt_s      = REQ_LEN - LEN_ONE;
            if (REQ_LEN == LEN_ZERO) begin
              state_s = ST_DRAIN;
            end else begin
              state_s = ST_READ;
            end
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (WD_VALID) begin
          nce_s      = 1'b0;
          nwrt_s     = 1'b0;
          pin_addr_s = addr_r;
          din_s      = WDATA;
          addr_s     = addr_r + ADDR_ONE;
          if (cnt_r == LEN_ZERO) begin
            state_s = ST_WDONE;
          end else begin
            cnt_s = cnt_r - LEN_ONE;
          end
        end else begin
          // Bubble: pins idle, address and data hold.
          state_s = ST_WRITE;
        end
      end

      ST_WDONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end

      ST_READ: begin
        nce_s      = 1'b0;
        pin_addr_s = addr_r;
        issue_rd_s = 1'b1;
        addr_s     = addr_r + ADDR_ONE;
        if (cnt_r == LEN_ZERO) begin
          state_s = ST_DRAIN;
        end else begin
          cnt_s = cnt_r - LEN_ONE;
        end
      end

      ST_DRAIN: begin
        // Leave once no command is on the pins any more; DONE lands in
        // the same cycle as the last RD_VALID.
        if (!pipe_r[0]) begin
          state_s = ST_IDLE;
          done_s  = pipe_r[1];
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Read data capture value: DO is only meaningful behind a tracked read
  always_comb begin
    if (pipe_r[1]) begin
      rdata_s = DO;
    end else begin
      rdata_s = rdata_r;
    end
  end

  // Control state, address counter and beat counter
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_r <= ST_IDLE;
      addr_r  <= {AW{1'b0}};
      cnt_r   <= LEN_ZERO;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered macro pins
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      nce_r      <= 1'b1;
      nwrt_r     <= 1'b1;
      pin_addr_r <= {AW{1'b0}};
      din_r      <= {DW{1'b0}};
    end else begin
      nce_r      <= nce_s;
      nwrt_r     <= nwrt_s;
      pin_addr_r <= pin_addr_s;
      din_r      <= din_s;
    end
  end

  // Read tracking pipe and registered client-side read/done outputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      pipe_r     <= 2'b00;
      rd_valid_r <= 1'b0;
      rdata_r    <= {DW{1'b0}};
      done_r     <= 1'b0;
    end else begin
      pipe_r     <= {pipe_r[0], issue_rd_s};
      rd_valid_r <= pipe_r[1];
      rdata_r    <= rdata_s;
      done_r     <= done_s;
    end
  end

  assign REQ_READY = (state_r == ST_IDLE);
  assign WD_READY  = (state_r == ST_WRITE);
  assign NCE       = nce_r;
  assign NWRT      = nwrt_r;
  assign RA        = pin_addr_r[AW-1:CAW];
  assign CA        = pin_addr_r[CAW-1:0];
  assign DIN       = din_r;
  assign RDATA     = rdata_r;
  assign RD_VALID  = rd_valid_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_access_ctrl
//
// Bench for rf_access_ctrl. A behavioural macro model answers the pins. The
// reference is a per-cycle timeline of expected outputs, filled in by the
// stimulus tasks from the transaction rules (command cycles, read latency,
// DONE/READY windows) and a plain memory array; one monitor compares every
// output against it on each falling edge. A few directed literal checks pin
// the reference itself.
// -----------------------------------------------------------------------------
module tb_rf_access_ctrl;

  localparam int DW   = 16;
  localparam int RAW  = 6;
  localparam int CAW  = 2;
  localparam int LENW = 3;
  localparam int MAXC = 8192;

  localparam bit [1:0] CMD_NONE = 2'd0;
  localparam bit [1:0] CMD_WR   = 2'd1;
  localparam bit [1:0] CMD_RD   = 2'd2;

  logic            CLK = 1'b0;
  logic            NRST = 1'b1;
  logic            REQ_VALID = 1'b0;
  logic            REQ_READY;
  logic            REQ_WR = 1'b0;
  logic [7:0]      REQ_ADDR = 8'h00;
  logic [LENW-1:0] REQ_LEN = 3'd0;
  logic [DW-1:0]   WDATA = 16'h0000;
  logic            WD_VALID = 1'b0;
  logic            WD_READY;
  logic [DW-1:0]   RDATA;
  logic            RD_VALID;
  logic            DONE;
  logic            NCE;
  logic            NWRT;
  logic [RAW-1:0]  RA;
  logic [CAW-1:0]  CA;
  logic [DW-1:0]   DIN;
  logic [DW-1:0]   DO = 16'h0000;

  rf_access_ctrl #(.DW(DW), .RAW(RAW), .CAW(CAW), .LENW(LENW)) dut (
    .CLK(CLK), .NRST(NRST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
    .WDATA(WDATA), .WD_VALID(WD_VALID), .WD_READY(WD_READY),
    .RDATA(RDATA), .RD_VALID(RD_VALID), .DONE(DONE),
    .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .DO(DO)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] init_word(input int a);
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  // Macro model: 256x16 synchronous RF, command sampled on posedge
  logic [DW-1:0] macro_mem [256];
  bit            macro_wr  [256];
  always @(posedge CLK) begin
    if (!NCE) begin
      if (!NWRT) begin
        macro_mem[{RA, CA}] <= DIN;
        macro_wr[{RA, CA}]  <= 1'b1;
      end else begin
        DO <= macro_wr[{RA, CA}] ? macro_mem[{RA, CA}] : init_word(int'({RA, CA}));
      end
    end
  end

  // Reference state
  logic [15:0] model_mem [256];
  bit [1:0]    e_cmd   [MAXC];
  bit [7:0]    e_addr  [MAXC];
  bit [15:0]   e_din   [MAXC];
  bit          e_rdv   [MAXC];
  bit [15:0]   e_rdata [MAXC];
  bit          e_done  [MAXC];
  bit          e_busy  [MAXC];
  bit          e_wdr   [MAXC];

  int          cyc = 0;
  int          free_c = 0;
  bit          wr_active = 1'b0;
  logic [15:0] wbuf [8];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  run_addr = 8'h00;
  logic [15:0] run_din = 16'h0000;
  logic [15:0] run_rdata = 16'h0000;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endfunction

  // Advance to just after the next rising edge; noise on WD_VALID when no
  // write burst is being fed (the DUT must ignore it).
  task automatic step();
    @(posedge CLK);
    #1;
    if (!wr_active) begin
      WD_VALID = 1'($urandom_range(0, 1));
      WDATA    = 16'($urandom);
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [2:0] len);
    int a;
    int n;
    REQ_VALID = 1'b1; REQ_WR = 1'b0; REQ_ADDR = addr; REQ_LEN = len;
    while (cyc < free_c) step();
    a = cyc;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      e_cmd[a+1+i]   = CMD_RD;
      e_addr[a+1+i]  = addr + 8'(i);
      e_busy[a+1+i]  = 1'b1;
      e_rdv[a+3+i]   = 1'b1;
      e_rdata[a+3+i] = model_mem[8'(addr + 8'(i))];
    end
    e_busy[a+n+1] = 1'b1;
    e_done[a+n+2] = 1'b1;
    free_c = a + n + 2;
    step();
    REQ_VALID = 1'b0;
  endtask

  // Returns in the cycle the last write command is on the pins.
  task automatic do_write(input logic [7:0] addr, input logic [2:0] len,
                          input int gap_beat, input int gap_len, input int rnd_pct);
    int i;
    int g;
    int c;
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = addr; REQ_LEN = len;
    while (cyc < free_c) step();
    wr_active = 1'b1;
    step();
    REQ_VALID = 1'b0;
    i = 0;
    g = 0;
    while (i <= int'(len)) begin
      c = cyc;
      e_busy[c] = 1'b1;
      e_wdr[c]  = 1'b1;
      if ((i == gap_beat && g < gap_len) || int'($urandom_range(0, 99)) < rnd_pct) begin
        WD_VALID = 1'b0;
        WDATA    = 16'($urandom);
        if (i == gap_beat) g++;
      end else begin
        WD_VALID = 1'b1;
        WDATA    = wbuf[i];
        e_cmd[c+1]  = CMD_WR;
        e_addr[c+1] = addr + 8'(i);
        e_din[c+1]  = wbuf[i];
        model_mem[8'(addr + 8'(i))] = wbuf[i];
        i++;
      end
      step();
    end
    wr_active = 1'b0;
    WD_VALID  = 1'b1;
    WDATA     = 16'($urandom);
    e_busy[cyc]   = 1'b1;
    e_done[cyc+1] = 1'b1;
    free_c = cyc + 1;
  endtask

  task automatic apply_reset(input int hold);
    NRST = 1'b0;
    REQ_VALID = 1'b0;
    wr_active = 1'b0;
    for (int c = cyc; c < MAXC; c++) begin
      e_cmd[c] = CMD_NONE; e_addr[c] = 8'h00; e_din[c] = 16'h0000; e_rdv[c] = 1'b0;
      e_rdata[c] = 16'h0000; e_done[c] = 1'b0; e_busy[c] = 1'b0; e_wdr[c] = 1'b0;
    end
    #1;
    chk("rst_nce", NCE, 1'b1);
    chk("rst_nwrt", NWRT, 1'b1);
    chk("rst_rd_valid", RD_VALID, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_req_ready", REQ_READY, 1'b1);
    for (int k = 0; k < hold; k++) step();
    NRST = 1'b1;
    free_c = cyc;
  endtask

  logic [15:0] burst_w [4];
  logic [7:0]  addr;
  logic [7:0]  last_wr_addr;
  logic [2:0]  len;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
    burst_w[0] = 16'hA0A0; burst_w[1] = 16'hA1A1;
    burst_w[2] = 16'hA2A2; burst_w[3] = 16'hA3A3;
    last_wr_addr = 8'h05;

    fork
      forever begin
        @(posedge CLK);
        cyc = cyc + 1;
      end
      forever begin
        @(negedge CLK);
        if (cyc < MAXC) begin
          if (!NRST) begin
            run_addr = 8'h00; run_din = 16'h0000; run_rdata = 16'h0000;
          end else begin
            if (e_cmd[cyc] != CMD_NONE) run_addr = e_addr[cyc];
            if (e_cmd[cyc] == CMD_WR) run_din = e_din[cyc];
            if (e_rdv[cyc]) run_rdata = e_rdata[cyc];
          end
          chk("NCE", NCE, e_cmd[cyc] == CMD_NONE);
          chk("NWRT", NWRT, e_cmd[cyc] != CMD_WR);
          chk("RA_CA", {RA, CA}, run_addr);
          chk("DIN", DIN, run_din);
          chk("RD_VALID", RD_VALID, e_rdv[cyc]);
          chk("RDATA", RDATA, run_rdata);
          chk("DONE", DONE, e_done[cyc]);
          chk("REQ_READY", REQ_READY, !e_busy[cyc]);
          chk("WD_READY", WD_READY, e_wdr[cyc]);
        end
      end
    join_none

    @(posedge CLK);
    #1;
    apply_reset(3);
    chk("rst_rdata", RDATA, 16'h0000);
    chk("rst_ra", RA, 6'h00);
    chk("rst_din", DIN, 16'h0000);

    // Single write 0x1234 @0x05, then read back requested in the DONE cycle
    wbuf[0] = 16'h1234;
    do_write(8'h05, 3'd0, -1, 0, 0);
    chk("w1_nce", NCE, 1'b0);
    chk("w1_nwrt", NWRT, 1'b0);
    chk("w1_ra", RA, 6'h01);
    chk("w1_ca", CA, 2'd1);
    chk("w1_din", DIN, 16'h1234);
    step();
    chk("w1_done", DONE, 1'b1);
    chk("w1_ready_in_done", REQ_READY, 1'b1);
    do_read(8'h05, 3'd0);
    chk("r1_nce", NCE, 1'b0);
    chk("r1_nwrt", NWRT, 1'b1);
    chk("r1_ra", RA, 6'h01);
    chk("r1_ca", CA, 2'd1);
    step();
    step();
    chk("r1_rd_valid", RD_VALID, 1'b1);
    chk("r1_rdata", RDATA, 16'h1234);
    chk("r1_done", DONE, 1'b1);

    // Burst across the 0xFF->0x00 wrap
    for (int i = 0; i < 4; i++) wbuf[i] = burst_w[i];
    do_write(8'hFE, 3'd3, -1, 0, 0);
    chk("wb_last_ra", RA, 6'h00);
    chk("wb_last_ca", CA, 2'd1);
    step();
    do_read(8'hFE, 3'd3);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rb_rd_valid", RD_VALID, 1'b1);
      chk("rb_rdata", RDATA, burst_w[i]);
      step();
    end

    // Write with a 2-cycle WD_VALID gap between the first and second beat
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
    do_write(8'h40, 3'd2, 1, 2, 0);
    chk("wg_last_ra", RA, 6'h10);
    chk("wg_last_ca", CA, 2'd2);
    chk("wg_last_din", DIN, 16'h3333);

    // Held request during a busy read burst, then another read queued behind it
    do_read(8'h3E, 3'd7);
    do_read(8'h40, 3'd2);

    // Reset in the middle of an 8-beat read
    do_read(8'h80, 3'd7);
    step();
    step();
    apply_reset(2);
    chk("post_rst_ready", REQ_READY, 1'b1);
    for (int k = 0; k < 10; k++) step();

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      int idle;
      idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) step();
      len = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        addr = 8'($urandom);
        last_wr_addr = addr;
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        do_write(addr, len, -1, 0, 25);
      end else begin
        if ($urandom_range(0, 1) == 1) addr = last_wr_addr + 8'($urandom_range(0, 3));
        else addr = 8'($urandom);
        do_read(addr, len);
      end
    end

    for (int k = 0; k < 15; k++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
